// File: rtl/switch_irq_port_if.sv
// switch_irq_port_if
//   Processor data-bus bundle for the switch/key input port.
//   master: the bus side (drives strobes, address, write data).
//   slave : the device side (returns read data).
//   we         write strobe
//   re         read strobe
//   memAddr    byte address
//   dataBusIn  write data
//   dataBusOut read data, zero when the device is not selected
interface switch_irq_port_if #(
    parameter int unsigned BITS = 32
);
    logic            we;
    logic            re;
    logic [BITS-1:0] memAddr;
    logic [BITS-1:0] dataBusIn;
    logic [BITS-1:0] dataBusOut;

    modport master (output we, re, memAddr, dataBusIn, input dataBusOut);
    modport slave  (input we, re, memAddr, dataBusIn, output dataBusOut);
endinterface

// File: rtl/switch_irq_port.sv
// switch_irq_port
//   Memory-mapped switch/key input port. Each of SW_WIDTH raw inputs is
//   synchronised, debounced over a programmable interval and edge-captured
//   into a write-1-to-clear pending register. A maskable interrupt is raised
//   from the READY flag (any stable change) or from masked pending edges.
//
//   Registers (byte offsets from BASE):
//     0x00 DATA   RO   stable switch state; reading clears READY
//     0x04 CTRL        bit0 READY (RO), bit2 OVR (write 0 clears),
//                      bit4 RISE_EN, bit5 FALL_EN, bit8 IE
//     0x08 PEND   W1C  per-channel captured edges
//     0x0C MASK   RW   per-channel interrupt enable
//     0x10 DBTIME RW   debounce interval in cycles (commit after DBTIME+1)
//
//   Ports:
//     clk         system clock
//     reset       synchronous, active-high reset
//     bus         data-bus slave (we, re, memAddr, dataBusIn, dataBusOut)
//     sw          raw asynchronous switch inputs
//     inta_ready  level interrupt request, active-high
module switch_irq_port #(
    parameter int unsigned      SW_WIDTH      = 10,
    parameter int unsigned      BITS          = 32,
    parameter logic [BITS-1:0]  BASE          = 32'hF0000010,
    parameter int unsigned      DEBOUNCE_TIME = 100000,
    parameter int unsigned      CNT_BITS      = 20
) (
    input  logic                clk,
    input  logic                reset,
    switch_irq_port_if.slave    bus,
    input  logic [SW_WIDTH-1:0] sw,
    output logic                inta_ready
);

    localparam logic [BITS-1:0]     ADDR_DATA = BASE;
    localparam logic [BITS-1:0]     ADDR_CTRL = BASE + BITS'(4);
    localparam logic [BITS-1:0]     ADDR_PEND = BASE + BITS'(8);
    localparam logic [BITS-1:0]     ADDR_MASK = BASE + BITS'(12);
    localparam logic [BITS-1:0]     ADDR_DBT  = BASE + BITS'(16);
    localparam logic [CNT_BITS-1:0] DBT_RESET = CNT_BITS'(DEBOUNCE_TIME);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic selData, selCtrl, selPend, selMask, selDbt;
    logic rdEn, dataRd, ctrlWr, pendWr, maskWr, dbtWr;

    always_comb begin
        selData = (bus.memAddr == ADDR_DATA);
        selCtrl = (bus.memAddr == ADDR_CTRL);
        selPend = (bus.memAddr == ADDR_PEND);
        selMask = (bus.memAddr == ADDR_MASK);
        selDbt  = (bus.memAddr == ADDR_DBT);
        // A cycle with both strobes counts as a write only.
        rdEn    = bus.re & ~bus.we;
        dataRd  = rdEn & selData;
        ctrlWr  = bus.we & selCtrl;
        pendWr  = bus.we & selPend;
        maskWr  = bus.we & selMask;
        dbtWr   = bus.we & selDbt;
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] s1, s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] st;
    logic [CNT_BITS-1:0] cnt [SW_WIDTH];
    logic [CNT_BITS-1:0] dbTime;
    logic [SW_WIDTH-1:0] chg;
    logic                anyChg;

    // Compare with >= so that lowering DBTIME below a running count commits
    // on the next cycle instead of letting the counter run to wrap.
    always_comb begin
        chg = '0;
        for (int unsigned i = 0; i < SW_WIDTH; i++) begin
            chg[i] = (s2[i] != st[i]) && (cnt[i] >= dbTime);
        end
        anyChg = |chg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= '0;
            for (int unsigned i = 0; i < SW_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SW_WIDTH; i++) begin
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (chg[i]) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_BITS'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control, pending and mask registers
    // ------------------------------------------------------------------
    logic                ready, ovr, riseEn, fallEn, ie;
    logic [SW_WIDTH-1:0] pend, mask;
    logic [SW_WIDTH-1:0] edgeHit;
    logic [SW_WIDTH-1:0] pendClr;

    // On a committing channel the new stable value is the current s2.
    always_comb begin
        edgeHit = chg & ((s2 & {SW_WIDTH{riseEn}}) | (~s2 & {SW_WIDTH{fallEn}}));
        pendClr = pendWr ? bus.dataBusIn[SW_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready  <= 1'b0;
            ovr    <= 1'b0;
            riseEn <= 1'b1;
            fallEn <= 1'b1;
            ie     <= 1'b0;
            pend   <= '0;
            mask   <= '0;
            dbTime <= DBT_RESET;
        end else begin
            // A change landing on the same edge as a DATA read keeps READY set.
            if (anyChg) begin
                ready <= 1'b1;
            end else if (dataRd) begin
                ready <= 1'b0;
            end

            // Overrun only when an unread change is about to be overwritten;
            // the set takes priority over a simultaneous write-0.
            if (anyChg && ready && !dataRd) begin
                ovr <= 1'b1;
            end else if (ctrlWr && !bus.dataBusIn[2]) begin
                ovr <= 1'b0;
            end

            if (ctrlWr) begin
                riseEn <= bus.dataBusIn[4];
                fallEn <= bus.dataBusIn[5];
                ie     <= bus.dataBusIn[8];
            end

            // New edges win over a simultaneous write-1-to-clear.
            pend <= (pend & ~pendClr) | edgeHit;

            if (maskWr) begin
                mask <= bus.dataBusIn[SW_WIDTH-1:0];
            end

            if (dbtWr) begin
                dbTime <= bus.dataBusIn[CNT_BITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    logic [BITS-1:0] rdData;

    always_comb begin
        rdData = '0;
        if (rdEn) begin
            if (selData) begin
                rdData[SW_WIDTH-1:0] = st;
            end else if (selCtrl) begin
                rdData[0] = ready;
                rdData[2] = ovr;
                rdData[4] = riseEn;
                rdData[5] = fallEn;
                rdData[8] = ie;
            end else if (selPend) begin
                rdData[SW_WIDTH-1:0] = pend;
            end else if (selMask) begin
                rdData[SW_WIDTH-1:0] = mask;
            end else if (selDbt) begin
                rdData[CNT_BITS-1:0] = dbTime;
            end
        end
    end

    assign bus.dataBusOut = rdData;
    assign inta_ready     = (ie & ready) | (|(pend & mask));

endmodule

// File: tb/tb_switch_irq_port.sv
// tb_switch_irq_port
//   Bench for switch_irq_port: a table of register read/write vectors,
//   hand-written sequences for the timing corner cases, and a randomized
//   phase compared every cycle against a reference model. The model derives
//   debouncing from a history of sampled inputs: a channel flips when the
//   last DBTIME+1 synchronised samples all disagree with its stable value.
module tb_switch_irq_port;

    localparam int unsigned SWW    = 10;
    localparam int unsigned HDEPTH = 64;
    localparam logic [31:0] A_DATA = 32'hF0000010;
    localparam logic [31:0] A_CTRL = 32'hF0000014;
    localparam logic [31:0] A_PEND = 32'hF0000018;
    localparam logic [31:0] A_MASK = 32'hF000001C;
    localparam logic [31:0] A_DBT  = 32'hF0000020;
    localparam logic [31:0] A_NONE = 32'hF0000024;
    localparam logic [31:0] A_MIS  = 32'hF0000012;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [SWW-1:0] sw = '0;
    logic           irq;
    logic           checkEn = 1'b0;
    int             checks = 0;
    int             failures = 0;
    logic [31:0]    got;

    switch_irq_port_if #(.BITS(32)) bus ();

    switch_irq_port #(
        .SW_WIDTH     (SWW),
        .BITS         (32),
        .BASE         (32'hF0000010),
        .DEBOUNCE_TIME(100000),
        .CNT_BITS     (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sw         (sw),
        .inta_ready (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus.memAddr   = a;
        bus.dataBusIn = d;
        bus.re        = 1'b0;
        bus.we        = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        bus.memAddr = a;
        bus.we      = 1'b0;
        bus.re      = 1'b1;
        #1;
        d = bus.dataBusOut;
        @(posedge clk);
        #1;
        bus.re = 1'b0;
    endtask

    // Combinational look at a register without reaching a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.memAddr = a;
        bus.we      = 1'b0;
        bus.re      = 1'b1;
        #1;
        d = bus.dataBusOut;
        bus.re = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [SWW-1:0] hist [HDEPTH];
    logic [SWW-1:0] mSt, mPend, mMask, mFlip, mEdge, mNewSt;
    logic           mReady, mOvr, mRise, mFall, mIe;
    logic [19:0]    mDb;
    logic           mDataRd, mCtrlWr, mPendWr, mMaskWr, mDbtWr;

    // hist[0] is sw from the previous edge, so hist[1] is what the
    // synchroniser presents at this edge.
    function automatic logic [SWW-1:0] flipMask();
        logic [SWW-1:0] f = '0;
        int             win = int'(mDb) + 1;
        if (win < HDEPTH) begin
            for (int c = 0; c < SWW; c++) begin
                f[c] = 1'b1;
                for (int k = 1; k <= win; k++) begin
                    if (hist[k][c] == mSt[c]) f[c] = 1'b0;
                end
            end
        end
        return f;
    endfunction

    always_comb begin
        mFlip   = flipMask();
        mNewSt  = mSt ^ mFlip;
        mEdge   = mFlip & ((mNewSt & {SWW{mRise}}) | (~mNewSt & {SWW{mFall}}));
        mDataRd = bus.re && !bus.we && bus.memAddr == A_DATA;
        mCtrlWr = bus.we && bus.memAddr == A_CTRL;
        mPendWr = bus.we && bus.memAddr == A_PEND;
        mMaskWr = bus.we && bus.memAddr == A_MASK;
        mDbtWr  = bus.we && bus.memAddr == A_DBT;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HDEPTH; k++) hist[k] <= '0;
            mSt <= '0; mPend <= '0; mMask <= '0;
            mReady <= 1'b0; mOvr <= 1'b0; mIe <= 1'b0;
            mRise <= 1'b1; mFall <= 1'b1; mDb <= 20'd100000;
        end else begin
            for (int k = HDEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= sw;
            mSt <= mNewSt;
            if (|mFlip) mReady <= 1'b1;
            else if (mDataRd) mReady <= 1'b0;
            if (|mFlip && mReady && !mDataRd) mOvr <= 1'b1;
            else if (mCtrlWr && !bus.dataBusIn[2]) mOvr <= 1'b0;
            if (mCtrlWr) begin
                mRise <= bus.dataBusIn[4];
                mFall <= bus.dataBusIn[5];
                mIe   <= bus.dataBusIn[8];
            end
            mPend <= (mPendWr ? (mPend & ~bus.dataBusIn[SWW-1:0]) : mPend) | mEdge;
            if (mMaskWr) mMask <= bus.dataBusIn[SWW-1:0];
            if (mDbtWr) mDb <= bus.dataBusIn[19:0];
        end
    end

    function automatic logic [31:0] expRead();
        logic [31:0] r = '0;
        if (bus.re && !bus.we) begin
            if (bus.memAddr == A_DATA)      r[SWW-1:0] = mSt;
            else if (bus.memAddr == A_CTRL) r = {23'b0, mIe, 2'b0, mFall, mRise, 1'b0, mOvr, 1'b0, mReady};
            else if (bus.memAddr == A_PEND) r[SWW-1:0] = mPend;
            else if (bus.memAddr == A_MASK) r[SWW-1:0] = mMask;
            else if (bus.memAddr == A_DBT)  r[19:0] = mDb;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("rand_rdata", bus.dataBusOut, expRead());
            check("rand_irq", {31'b0, irq}, {31'b0, (mIe & mReady) | (|(mPend & mMask))});
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        doWr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addrs[7];
        int          op;

        vecs[0]  = '{"rst_data",     A_DATA, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{"rst_ctrl",     A_CTRL, 1'b0, 32'h0,        32'h30};
        vecs[2]  = '{"rst_pend",     A_PEND, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{"rst_mask",     A_MASK, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{"rst_dbtime",   A_DBT,  1'b0, 32'h0,        32'd100000};
        vecs[5]  = '{"w1c_idle",     A_PEND, 1'b1, 32'h3FF,      32'h0};
        vecs[6]  = '{"mask_all",     A_MASK, 1'b1, 32'hFFFFFFFF, 32'h3FF};
        vecs[7]  = '{"dbt_all",      A_DBT,  1'b1, 32'hFFFFFFFF, 32'hFFFFF};
        vecs[8]  = '{"ctrl_all",     A_CTRL, 1'b1, 32'hFFFFFFFF, 32'h130};
        vecs[9]  = '{"ctrl_zero",    A_CTRL, 1'b1, 32'h0,        32'h0};
        vecs[10] = '{"data_ro",      A_DATA, 1'b1, 32'hFFF,      32'h0};
        vecs[11] = '{"unmapped",     A_NONE, 1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{"misaligned",   A_MIS,  1'b0, 32'h0,        32'h0};
        addrs = '{A_DATA, A_CTRL, A_PEND, A_MASK, A_DBT, A_NONE, A_MIS};

        bus.we = 1'b0; bus.re = 1'b0; bus.memAddr = '0; bus.dataBusIn = '0;
        step(3);
        reset = 1'b0;

        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].doWr) busWrite(vecs[i].addr, vecs[i].wdata);
            peek(vecs[i].addr, got);
            check(vecs[i].name, got, vecs[i].exp);
        end
        check("table_irq", {31'b0, irq}, 32'h0);
        busWrite(A_CTRL, 32'h30);
        busWrite(A_MASK, 32'h0);
        busWrite(A_DBT, 32'd3);

        // Latency: DBTIME=3 commits on the 6th edge after sw rises.
        sw[0] = 1'b1;
        step(5);
        peek(A_DATA, got); check("lat_early", got, 32'h0);
        step(1);
        peek(A_DATA, got); check("lat_commit", got, 32'h1);
        peek(A_CTRL, got); check("lat_ctrl", got, 32'h31);
        peek(A_PEND, got); check("lat_pend", got, 32'h1);
        check("lat_irq_off", {31'b0, irq}, 32'h0);

        // A 3-cycle pulse is filtered.
        sw[1] = 1'b1; step(3); sw[1] = 1'b0; step(10);
        peek(A_DATA, got); check("glitch", got, 32'h1);

        // READY interrupt and DATA read clear.
        busWrite(A_CTRL, 32'h130);
        check("ie_irq", {31'b0, irq}, 32'h1);
        busRead(A_DATA, got); check("ie_read", got, 32'h1);
        check("ie_irq_clr", {31'b0, irq}, 32'h0);
        peek(A_CTRL, got); check("ie_ctrl", got, 32'h130);

        // Two changes without a read set OVR; write 0 clears it, keeps IE.
        sw[1] = 1'b1; step(10); sw[1] = 1'b0; step(10);
        peek(A_CTRL, got); check("ovr_set", got, 32'h135);
        busWrite(A_CTRL, 32'h130);
        peek(A_CTRL, got); check("ovr_clr", got, 32'h131);
        check("ovr_irq", {31'b0, irq}, 32'h1);
        busRead(A_DATA, got); check("ovr_data", got, 32'h1);
        busWrite(A_PEND, 32'h3FF);
        peek(A_PEND, got); check("pend_clr_all", got, 32'h0);
        check("pend_clr_irq", {31'b0, irq}, 32'h0);

        // Masked rising edge only.
        busWrite(A_MASK, 32'h4);
        busWrite(A_CTRL, 32'h010);
        sw[2] = 1'b1; step(10);
        peek(A_PEND, got); check("rise_pend", got, 32'h4);
        check("rise_irq", {31'b0, irq}, 32'h1);
        busWrite(A_PEND, 32'h4);
        peek(A_PEND, got); check("w1c_pend", got, 32'h0);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        sw[2] = 1'b0; step(10);
        peek(A_PEND, got); check("fall_no_pend", got, 32'h0);
        check("fall_irq", {31'b0, irq}, 32'h0);
        sw[2] = 1'b1; step(5);
        busWrite(A_PEND, 32'h4);
        peek(A_PEND, got); check("edge_beats_w1c", got, 32'h4);
        check("edge_w1c_irq", {31'b0, irq}, 32'h1);
        busWrite(A_CTRL, 32'h010);
        peek(A_CTRL, got); check("ovr_clr2", got, 32'h011);

        // DATA read on the commit edge: READY stays, no overrun.
        sw[3] = 1'b1; step(5);
        busRead(A_DATA, got); check("rd_chg_data", got, 32'h005);
        peek(A_CTRL, got); check("rd_chg_ctrl", got, 32'h011);
        peek(A_DATA, got); check("rd_chg_st", got, 32'h00D);

        // Overrun set against a simultaneous write-0.
        sw[4] = 1'b1; step(5);
        busWrite(A_CTRL, 32'h010);
        peek(A_CTRL, got); check("ovr_set_wins", got, 32'h015);

        // Lowering DBTIME mid-count commits on the following cycle.
        busWrite(A_DBT, 32'd50);
        sw[5] = 1'b1; step(22);
        busWrite(A_DBT, 32'd5);
        peek(A_DATA, got); check("dbt_low_pre", got, 32'h01D);
        step(1);
        peek(A_DATA, got); check("dbt_low_commit", got, 32'h03D);

        // Reset mid-count.
        sw[6] = 1'b1; step(5);
        reset = 1'b1; step(1); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            peek(vecs[i].addr, got);
            check({"mid_", vecs[i].name}, got, vecs[i].exp);
        end
        check("mid_rst_irq", {31'b0, irq}, 32'h0);

        // Inputs held through reset rise after release.
        busWrite(A_DBT, 32'd0);
        step(4);
        peek(A_DATA, got); check("held_rise", got, 32'h07D);
        peek(A_PEND, got); check("held_pend", got, 32'h07D);

        // Randomized phase against the model.
        sw = '0;
        reset = 1'b1; step(2); reset = 1'b0;
        checkEn = 1'b1;
        busWrite(A_DBT, 32'($urandom_range(0, 4)));
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < SWW; b++) begin
                if ($urandom_range(0, 19) == 0) sw[b] = ~sw[b];
            end
            op = int'($urandom_range(0, 9));
            bus.memAddr   = addrs[$urandom_range(0, 6)];
            bus.dataBusIn = $urandom;
            bus.re        = (op >= 4 && op <= 6) || op == 9;
            bus.we        = (op >= 7);
            if (bus.we && bus.memAddr == A_DBT) bus.dataBusIn = 32'($urandom_range(0, 7));
            reset = ($urandom_range(0, 999) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        bus.we = 1'b0;
        bus.re = 1'b0;
        @(negedge clk);
        checkEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
